// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial line input and CPU-side data/status signals of the UART receiver.
interface uart_rx_ctrl_if;
    logic       UART_RX;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_status;
    logic       frame_err;
    logic       overrun;
    modport master (
        output UART_RX, rd_ack,
        input  rx_data, rx_valid, rx_status, frame_err, overrun
    );
    modport slave (
        input  UART_RX, rd_ack,
        output rx_data, rx_valid, rx_status, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver, 16x oversampled, LSB first, with sticky status/overrun flags.
module uart_rx_ctrl #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input logic           sys_clk,
    input logic           reset,
    uart_rx_ctrl_if.slave bus
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    samp_q, samp_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d, data_q, data_d;
    logic          status_q, status_d, ovr_q, ovr_d;
    logic          rx_s, tick, done, ferr;
    assign rx_s = sync_q[1];
    assign tick = tick_q == TW'(DIV - 1);
    always_comb begin
        state_d = state_q;
        tick_d  = tick ? '0 : tick_q + TW'(1);
        samp_d  = tick ? samp_q + 4'd1 : samp_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        done    = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                tick_d  = '0;
                samp_d  = '0;
            end
            START: if (tick && samp_q == 4'd7) begin
                state_d = rx_s ? IDLE : DATA;
                samp_d  = '0;
                bit_d   = '0;
            end
            DATA: if (tick && samp_q == 4'd15) begin
                sh_d[bit_q] = rx_s;
                bit_d       = bit_q + 3'd1;
                state_d     = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (tick && samp_q == 4'd15) begin
                done    = rx_s;
                ferr    = !rx_s;
                state_d = rx_s ? IDLE : BREAK;
            end
            BREAK: state_d = rx_s ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end
    // A completing byte beats a simultaneous rd_ack; overrun only sets when the old byte was unread.
    assign data_d   = done ? sh_q : data_q;
    assign status_d = done ? 1'b1 : (bus.rd_ack ? 1'b0 : status_q);
    assign ovr_d    = done ? (ovr_q | (status_q & ~bus.rd_ack)) : (bus.rd_ack ? 1'b0 : ovr_q);
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            tick_q   <= '0;
            samp_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            data_q   <= '0;
            status_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[0], bus.UART_RX};
            tick_q   <= tick_d;
            samp_q   <= samp_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            data_q   <= data_d;
            status_q <= status_d;
            ovr_q    <= ovr_d;
        end
    end
    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = done;
    assign bus.rx_status = status_q;
    assign bus.frame_err = ferr;
    assign bus.overrun   = ovr_q;
endmodule
